// File: rtl/corr_vacc_pkg.sv
// Shared definitions for the correlation vector accumulator: default widths
// and the log2 helper used to size channel indices.
package corr_vacc_pkg;

  localparam int DEF_DIN_WIDTH  = 37;
  localparam int DEF_DOUT_WIDTH = 48;
  localparam int DEF_VECTOR_LEN = 64;
  localparam int DEF_ACC_WIDTH  = 16;

  function automatic int vacc_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/vacc_lane.sv
// One accumulator column: BRAM holding {sticky_sat, value} per channel,
// first-spectrum overwrite mux and saturating adder (unsigned or signed).
module vacc_lane
  import corr_vacc_pkg::*;
#(
  parameter bit SIGNED     = 1'b0,
  parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int VECTOR_LEN = DEF_VECTOR_LEN,
  localparam int AW        = vacc_clog2(VECTOR_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [AW-1:0]         in_addr,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DIN_WIDTH-1:0]  in_data,
  output logic [DOUT_WIDTH-1:0] dout
);

  localparam logic [DOUT_WIDTH-1:0] UMAX = {DOUT_WIDTH{1'b1}};
  localparam logic [DOUT_WIDTH-1:0] SMAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] SMIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic                  pad_bit;
  logic [DOUT_WIDTH-1:0] in_ext;

  logic                  s1_valid;
  logic                  s1_first;
  logic                  s1_last;
  logic [AW-1:0]         s1_addr;
  logic [DOUT_WIDTH-1:0] s1_ext;

  logic [DOUT_WIDTH:0]   mem [VECTOR_LEN];
  logic [DOUT_WIDTH:0]   rd_q;
  logic [DOUT_WIDTH:0]   sum_w;
  logic                  ovf;
  logic [DOUT_WIDTH:0]   wr_word;

  assign pad_bit = SIGNED ? in_data[DIN_WIDTH-1] : 1'b0;
  assign in_ext  = {{(DOUT_WIDTH-DIN_WIDTH){pad_bit}}, in_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s1_ext   <= '0;
      dout     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_addr  <= in_addr;
      s1_ext   <= in_ext;
      if (s1_valid && s1_last) dout <= wr_word[DOUT_WIDTH-1:0];
    end
  end

  // BRAM column: no reset, the first spectrum always overwrites.
  always_ff @(posedge clk) begin
    if (s1_valid) mem[s1_addr] <= wr_word;
    rd_q <= mem[in_addr];
  end

  // MSB of each word is a sticky flag that pins a clamped lane until overwrite.
  always_comb begin
    sum_w   = '0;
    ovf     = 1'b0;
    wr_word = {1'b0, s1_ext};
    if (SIGNED) begin
      sum_w = {rd_q[DOUT_WIDTH-1], rd_q[DOUT_WIDTH-1:0]} + {s1_ext[DOUT_WIDTH-1], s1_ext};
      ovf   = sum_w[DOUT_WIDTH] ^ sum_w[DOUT_WIDTH-1];
    end else begin
      sum_w = {1'b0, rd_q[DOUT_WIDTH-1:0]} + {1'b0, s1_ext};
      ovf   = sum_w[DOUT_WIDTH];
    end
    if (!s1_first) begin
      if (rd_q[DOUT_WIDTH])
        wr_word = rd_q;
      else if (ovf)
        wr_word = {1'b1, SIGNED ? (sum_w[DOUT_WIDTH] ? SMIN : SMAX) : UMAX};
      else
        wr_word = {1'b0, sum_w[DOUT_WIDTH-1:0]};
    end
  end

endmodule

// File: rtl/corr_vacc.sv
// 2x2 correlation vector accumulator: channel/spectrum counters, first/last
// flags and output alignment around four vacc_lane columns.
module corr_vacc
  import corr_vacc_pkg::*;
#(
  parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int VECTOR_LEN = DEF_VECTOR_LEN,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  localparam int CW        = vacc_clog2(VECTOR_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din1_pow,
  input  logic [DIN_WIDTH-1:0]  din2_pow,
  input  logic [DIN_WIDTH-1:0]  corr_re,
  input  logic [DIN_WIDTH-1:0]  corr_im,
  input  logic                  din_valid,
  input  logic                  sync,
  input  logic [ACC_WIDTH-1:0]  acc_len,
  output logic [DOUT_WIDTH-1:0] r11,
  output logic [DOUT_WIDTH-1:0] r22,
  output logic [DOUT_WIDTH-1:0] r12_re,
  output logic [DOUT_WIDTH-1:0] r12_im,
  output logic [CW-1:0]         dout_chan,
  output logic                  dout_valid,
  output logic                  dout_last
);

  logic [CW-1:0]        chan_cnt;
  logic [ACC_WIDTH-1:0] spec_cnt;
  logic [ACC_WIDTH-1:0] acc_len_r;

  logic [CW-1:0]        cur_chan;
  logic [ACC_WIDTH-1:0] cur_spec;
  logic [ACC_WIDTH-1:0] len_in;
  logic [ACC_WIDTH-1:0] cur_len;
  logic                 is_start;
  logic                 is_first;
  logic                 is_last;
  logic                 chan_end;

  logic                 s0_valid;
  logic                 s0_first;
  logic                 s0_last;
  logic [CW-1:0]        s0_addr;
  logic [DIN_WIDTH-1:0] s0_p1;
  logic [DIN_WIDTH-1:0] s0_p2;
  logic [DIN_WIDTH-1:0] s0_re;
  logic [DIN_WIDTH-1:0] s0_im;

  logic                 s1_emit;
  logic [CW-1:0]        s1_addr;

  // sync folds into the current sample so it lands on channel 0, spectrum 0.
  always_comb begin
    cur_chan = sync ? '0 : chan_cnt;
    cur_spec = sync ? '0 : spec_cnt;
    len_in   = (acc_len == '0) ? ACC_WIDTH'(1) : acc_len;
    is_start = (cur_chan == '0) && (cur_spec == '0);
    cur_len  = is_start ? len_in : acc_len_r;
    is_first = (cur_spec == '0);
    is_last  = (cur_spec == cur_len - ACC_WIDTH'(1));
    chan_end = (cur_chan == CW'(VECTOR_LEN-1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chan_cnt  <= '0;
      spec_cnt  <= '0;
      acc_len_r <= '0;
    end else if (din_valid) begin
      chan_cnt <= cur_chan + CW'(1);
      if (chan_end) spec_cnt <= is_last ? '0 : cur_spec + ACC_WIDTH'(1);
      else          spec_cnt <= cur_spec;
      if (is_start) acc_len_r <= len_in;
    end else if (sync) begin
      chan_cnt <= '0;
      spec_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid   <= 1'b0;
      s0_first   <= 1'b0;
      s0_last    <= 1'b0;
      s0_addr    <= '0;
      s0_p1      <= '0;
      s0_p2      <= '0;
      s0_re      <= '0;
      s0_im      <= '0;
      s1_emit    <= 1'b0;
      s1_addr    <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_chan  <= '0;
    end else begin
      s0_valid   <= din_valid;
      s0_first   <= is_first;
      s0_last    <= is_last;
      s0_addr    <= cur_chan;
      s0_p1      <= din1_pow;
      s0_p2      <= din2_pow;
      s0_re      <= corr_re;
      s0_im      <= corr_im;
      s1_emit    <= s0_valid && s0_last;
      s1_addr    <= s0_addr;
      dout_valid <= s1_emit;
      dout_last  <= s1_emit && (s1_addr == CW'(VECTOR_LEN-1));
      if (s1_emit) dout_chan <= s1_addr;
    end
  end

  vacc_lane #(.SIGNED(1'b0), .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH), .VECTOR_LEN(VECTOR_LEN))
    u_r11 (.clk(clk), .rst(rst), .in_valid(s0_valid), .in_addr(s0_addr), .in_first(s0_first),
           .in_last(s0_last), .in_data(s0_p1), .dout(r11));
  vacc_lane #(.SIGNED(1'b0), .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH), .VECTOR_LEN(VECTOR_LEN))
    u_r22 (.clk(clk), .rst(rst), .in_valid(s0_valid), .in_addr(s0_addr), .in_first(s0_first),
           .in_last(s0_last), .in_data(s0_p2), .dout(r22));
  vacc_lane #(.SIGNED(1'b1), .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH), .VECTOR_LEN(VECTOR_LEN))
    u_r12_re (.clk(clk), .rst(rst), .in_valid(s0_valid), .in_addr(s0_addr), .in_first(s0_first),
              .in_last(s0_last), .in_data(s0_re), .dout(r12_re));
  vacc_lane #(.SIGNED(1'b1), .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH), .VECTOR_LEN(VECTOR_LEN))
    u_r12_im (.clk(clk), .rst(rst), .in_valid(s0_valid), .in_addr(s0_addr), .in_first(s0_first),
              .in_last(s0_last), .in_data(s0_im), .dout(r12_im));

endmodule

// File: tb/tb_corr_vacc.sv
// Scoreboard bench for corr_vacc (VECTOR_LEN=8, DOUT_WIDTH=48): a behavioural
// integrator predicts each emitted word and the cycle it must appear on.
module tb_corr_vacc;

  localparam int DW = 37;
  localparam int OW = 48;
  localparam int VL = 8;
  localparam int AW = 16;
  localparam int CW = 3;
  localparam longint UMAX = (longint'(1) << OW) - 1;
  localparam longint SMAX = (longint'(1) << (OW-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (OW-1));
  localparam longint PMAX = (longint'(1) << DW) - 1;
  localparam longint HALF = longint'(1) << (DW-1);

  logic          clk;
  logic          rst;
  logic [DW-1:0] din1_pow, din2_pow, corr_re, corr_im;
  logic          din_valid, sync;
  logic [AW-1:0] acc_len;
  logic [OW-1:0] r11, r22, r12_re, r12_im;
  logic [CW-1:0] dout_chan;
  logic          dout_valid, dout_last;

  corr_vacc #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .VECTOR_LEN(VL), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .din1_pow(din1_pow), .din2_pow(din2_pow),
    .corr_re(corr_re), .corr_im(corr_im), .din_valid(din_valid), .sync(sync),
    .acc_len(acc_len), .r11(r11), .r22(r22), .r12_re(r12_re), .r12_im(r12_im),
    .dout_chan(dout_chan), .dout_valid(dout_valid), .dout_last(dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int     cyc;
    int     chan;
    bit     last;
    longint r11, r22, re, im;
  } exp_t;
  exp_t q[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  longint m_acc [4][VL];
  bit     m_sat [4][VL];
  int     m_chan = 0;
  int     m_spec = 0;
  int     m_len  = 1;
  int     len_q  = 1;

  task automatic model_step(input longint p1, input longint p2, input longint re, input longint im);
    longint v [4];
    longint s;
    bit     first, last;
    exp_t   e;
    v = '{p1, p2, re, im};
    if (m_chan == 0 && m_spec == 0) m_len = (len_q == 0) ? 1 : len_q;
    first = (m_spec == 0);
    last  = (m_spec == m_len - 1);
    for (int l = 0; l < 4; l++) begin
      if (first) begin
        m_acc[l][m_chan] = v[l];
        m_sat[l][m_chan] = 1'b0;
      end else if (!m_sat[l][m_chan]) begin
        s = m_acc[l][m_chan] + v[l];
        if (l < 2 && s > UMAX)      begin m_acc[l][m_chan] = UMAX; m_sat[l][m_chan] = 1'b1; end
        else if (l >= 2 && s > SMAX) begin m_acc[l][m_chan] = SMAX; m_sat[l][m_chan] = 1'b1; end
        else if (l >= 2 && s < SMIN) begin m_acc[l][m_chan] = SMIN; m_sat[l][m_chan] = 1'b1; end
        else m_acc[l][m_chan] = s;
      end
    end
    if (last) begin
      e.cyc  = cyc + 3;
      e.chan = m_chan;
      e.last = (m_chan == VL-1);
      e.r11  = m_acc[0][m_chan];
      e.r22  = m_acc[1][m_chan];
      e.re   = m_acc[2][m_chan];
      e.im   = m_acc[3][m_chan];
      q.push_back(e);
    end
    m_chan++;
    if (m_chan == VL) begin
      m_chan = 0;
      m_spec = last ? 0 : m_spec + 1;
    end
  endtask

  task automatic drive(input bit v, input bit s, input longint p1, input longint p2,
                       input longint re, input longint im);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    acc_len   = AW'(len_q);
    din1_pow  = DW'(p1);
    din2_pow  = DW'(p2);
    corr_re   = DW'(re);
    corr_im   = DW'(im);
    if (s) begin m_chan = 0; m_spec = 0; end
    if (v) model_step(p1, p2, re, im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic rnd_sample(input bit s);
    drive(1'b1, s, longint'($urandom_range(0, 1000000)), longint'($urandom_range(0, 1000000)),
          longint'($urandom_range(0, 2000000)) - 1000000, longint'($urandom_range(0, 2000000)) - 1000000);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    rst = 1'b0;
    din_valid = 1'b0;
    sync = 1'b0;
    q.delete();
    m_chan = 0;
    m_spec = 0;
    repeat (n) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  exp_t e_mon;
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_valid", dout_valid, 0);
      check("rst_last", dout_last, 0);
      check("rst_chan", dout_chan, 0);
      check("rst_r11", r11, 0);
      check("rst_r22", r22, 0);
      check("rst_re", longint'($signed(r12_re)), 0);
      check("rst_im", longint'($signed(r12_im)), 0);
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      e_mon = q.pop_front();
      check("out_valid", dout_valid, 1);
      check("out_chan", dout_chan, e_mon.chan);
      check("out_last", dout_last, e_mon.last);
      check("out_r11", r11, e_mon.r11);
      check("out_r22", r22, e_mon.r22);
      check("out_re", longint'($signed(r12_re)), e_mon.re);
      check("out_im", longint'($signed(r12_im)), e_mon.im);
    end else if (dout_valid) begin
      check("spurious_valid", dout_valid, 0);
    end
  end

  initial begin
    rst = 1'b0;
    din_valid = 1'b0;
    sync = 1'b0;
    acc_len = '0;
    din1_pow = '0; din2_pow = '0; corr_re = '0; corr_im = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // constant inputs, 4-spectrum integration
    len_q = 4;
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    for (int i = 0; i < 4*VL; i++) drive(1'b1, 1'b0, 10, 7, -3, 5);
    idle(5);
    check("const_r11", r11, 40);
    check("const_r22", r22, 28);
    check("const_re", longint'($signed(r12_re)), -12);
    check("const_im", longint'($signed(r12_im)), 20);

    // acc_len 0 and 1 echo every spectrum
    len_q = 0;
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    for (int i = 0; i < 2*VL; i++) rnd_sample(1'b0);
    len_q = 1;
    for (int i = 0; i < 2*VL; i++) rnd_sample(1'b0);
    idle(4);

    // acc_len change mid-integration applies to the next one
    len_q = 2;
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    for (int i = 0; i < VL + 3; i++) rnd_sample(1'b0);
    len_q = 3;
    for (int i = 0; i < VL - 3 + 3*VL; i++) rnd_sample(1'b0);
    idle(4);

    // sync at channel 5 of spectrum 1 discards the partial integration
    len_q = 4;
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    for (int i = 0; i < VL + 5; i++) rnd_sample(1'b0);
    rnd_sample(1'b1);
    for (int i = 0; i < 4*VL - 1; i++) rnd_sample(1'b0);
    idle(4);

    // random gaps, reset mid-integration, then clean integration on stale BRAM
    len_q = 3;
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    for (int i = 0; i < 2*VL + 5; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      rnd_sample(1'b0);
    end
    do_reset(4);
    for (int i = 0; i < 3*VL; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      rnd_sample(1'b0);
    end
    idle(4);

    // saturation, then opposite-sign input must not pull lanes off the clamp
    len_q = 2052;
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    for (int s = 0; s < 2052; s++)
      for (int c = 0; c < VL; c++)
        if (s < 2049) drive(1'b1, 1'b0, PMAX, 5, -HALF, HALF - 1);
        else          drive(1'b1, 1'b0, PMAX, 5, HALF - 1, -HALF);
    idle(5);
    check("sat_r11", r11, UMAX);
    check("sat_r22", r22, 5 * 2052);
    check("sat_re", longint'($signed(r12_re)), SMIN);
    check("sat_im", longint'($signed(r12_im)), SMAX);

    // next first spectrum clears the clamp
    len_q = 1;
    for (int i = 0; i < VL; i++) rnd_sample(1'b0);
    idle(8);

    check("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/corr_vacc.md
# corr_vacc

Vector accumulator for the 2x2 spatial correlation stream: consumes per-channel r11, r22 and r12 (re/im) from the correlation multiplier stage, integrates each FFT channel over a programmable number of spectra in block RAM, and streams out the integrated matrix entries once per integration. It sits directly downstream of the correlation multipliers and upstream of the DoA eigen-solver.

## Interface
- DIN_WIDTH, 37: width of the incoming power and correlation words (2*18+1).
- DOUT_WIDTH, 48: width of the accumulated output words.
- VECTOR_LEN, 64: FFT channels per spectrum; power of two, at least 4.
- ACC_WIDTH, 16: width of the acc_len control word.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- din1_pow, din2_pow  in  DIN_WIDTH  unsigned r11, r22.
- corr_re, corr_im  in  DIN_WIDTH  signed r12 = x1·conj(x2).
- din_valid  in  1  one channel sample per asserted cycle; gaps allowed.
- sync  in  1  single-cycle pulse that restarts spectrum and integration alignment.
- acc_len  in  ACC_WIDTH  spectra per integration; 0 is treated as 1.
- r11, r22  out  DOUT_WIDTH  unsigned integrated powers.
- r12_re, r12_im  out  DOUT_WIDTH  signed integrated correlation.
- dout_chan  out  log2(VECTOR_LEN)  channel index of the current output.
- dout_valid  out  1  output word valid.
- dout_last  out  1  high with dout_valid on channel VECTOR_LEN-1.

## Operation
- Counters: chan_cnt (0..VECTOR_LEN-1) and spec_cnt (0..acc_len_r-1). chan_cnt advances on each din_valid and wraps to 0; spec_cnt advances when chan_cnt wraps.
- acc_len_r latches acc_len when chan_cnt=0 and spec_cnt=0 and din_valid is high. A mid-integration change to acc_len takes effect only at the next integration.
- First spectrum (spec_cnt=0): BRAM[chan] is overwritten with the sign/zero-extended input, with no read-add.
- Later spectra: BRAM[chan] is updated with BRAM[chan] + input as a read-modify-write.
- Last spectrum (spec_cnt=acc_len_r-1): the sum is presented on the outputs with dout_valid, and is also written back. The write-back is harmless because the next spectrum overwrites it.
- acc_len_r=1: every spectrum is emitted unmodified.
- Arithmetic:
  - r11 and r22 use unsigned saturating add (clamp at 2^DOUT_WIDTH-1).
  - r12 uses signed saturating add (clamp at ±(2^(DOUT_WIDTH-1)), max 2^(DOUT_WIDTH-1)-1).
  - A saturated lane stays saturated until its next first-spectrum overwrite.
- sync: chan_cnt and spec_cnt are zeroed. If sync and din_valid coincide, that sample is channel 0 of spectrum 0. Any partial integration is discarded and nothing is emitted for it. Samples already in the pipeline still complete.
- Reset (asynchronous, mid-operation allowed): counters, acc_len_r, pipeline valids and all outputs are cleared. BRAM contents are not cleared; the first-spectrum overwrite makes them irrelevant.

## Timing
- Pipeline stages:
  - Stage 0: register inputs, address and first/last flags.
  - Stage 1: BRAM read data available.
  - Stage 2: saturating add; write-back and output registers.
- Latency: a sample accepted at cycle t appears at cycle t+3 with dout_valid (last spectrum only).
- Read-modify-write hazard: the same address recurs no sooner than VECTOR_LEN ≥ 4 valid cycles later, so the write-back lands before the next read. No forwarding is needed.
- Throughput: one sample per cycle sustained. Output order equals input channel order.
- Reset values: r11=r22=r12_re=r12_im=0, dout_chan=0, dout_valid=0, dout_last=0.
- No backpressure: the downstream block must accept a full-rate burst of VECTOR_LEN words.

## Structure
- Shared package or header: saturation-limit constants and the clog2 helper for log2(VECTOR_LEN).
- Sub-module vacc_lane (parameter SIGNED): one BRAM column, the first-spectrum mux and the saturating adder. Instantiated 4 times (r11, r22, r12_re, r12_im).
- Top level holds only the counters, flags and output alignment.

## Test plan
Tests use VECTOR_LEN=8 and DOUT_WIDTH=48 unless stated.
- acc_len=4, constant inputs (pow=10, re=-3, im=5) for 4 spectra → one burst of 8 words: r11=40, r12_re=-12, r12_im=20; dout_last only on chan 7; first word 3 cycles after the first sample of spectrum 3.
- acc_len=0 and acc_len=1 → every spectrum echoed unchanged at latency 3.
- acc_len changed from 2 to 3 mid-integration → current integration emits 2-spectrum sums; the next emits 3-spectrum sums.
- DOUT_WIDTH=38, pow=2^36, acc_len=8 → r11 clamps at 2^38-1. corr_re=-2^36 clamps at -2^37.
- sync pulsed at chan 5 of spectrum 1 (acc_len=4) → no output for the partial integration; the next output equals a clean 4-spectrum sum.
- Random din_valid gaps plus rst asserted mid-integration → outputs zero while in reset; the first post-reset integration is correct despite stale BRAM.
